// File: rtl/ram_banked_init.sv
// ram_banked_init: byte-writable single-port RAM of 32-bit column banks with post-reset zero-fill.
module ram_banked_init #(
   parameter int WIDTH     = 64,
   parameter int COLS      = 2,
   parameter int ABITS     = 9,
   parameter int INIT_ZERO = 1,
   parameter int OUT_REG   = 0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic [WIDTH/8-1:0] WE,
   input  logic [ABITS-1:0]   A,
   input  logic [WIDTH-1:0]   Di,
   output logic [WIDTH-1:0]   Do,
   output logic               VALID,
   output logic               BUSY
);
   localparam int NBANKS = WIDTH / 32;
   localparam int DEPTH  = 256 * COLS;
   if (WIDTH % 32 != 0 || (1 << ABITS) != DEPTH) begin : g_bad_cfg
      $error("ram_banked_init: WIDTH must be a multiple of 32 and 2**ABITS must equal 256*COLS");
   end
   typedef enum logic {FILL, RUN} state_t;
   state_t state, nxt;
   logic [ABITS-1:0] cnt, addr;
   logic fill, acc, rd;
   logic [WIDTH/8-1:0] bwe;
   logic [WIDTH-1:0] wdat, rword, d1, d2;
   logic v1, v2;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= INIT_ZERO != 0 ? FILL : RUN;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= state == FILL ? cnt + 1'b1 : '0;
      end
   end
   always_comb nxt = (state == FILL && cnt == ABITS'(DEPTH - 1)) ? RUN : state;
   always_comb begin
      fill = state == FILL;
      BUSY = fill;
   end
   // fill owns the port completely; user requests only reach the banks in RUN
   assign acc  = EN & ~fill;
   assign rd   = acc & ~|WE;
   assign bwe  = fill ? '1 : (acc ? WE : '0);
   assign addr = fill ? cnt : A;
   assign wdat = fill ? '0 : Di;
   for (genvar k = 0; k < NBANKS; k++) begin : g_bank
      logic [31:0] mem [DEPTH];
      always_ff @(posedge CLK) begin
         for (int b = 0; b < 4; b++)
            if (bwe[4*k+b]) mem[addr][8*b +: 8] <= wdat[32*k+8*b +: 8];
      end
      assign rword[32*k +: 32] = mem[addr];
   end
   // data registers only load on a completed read, so Do holds across writes and idles
   always_ff @(posedge CLK) begin
      if (RST) begin
         d1 <= '0;
         v1 <= 1'b0;
         d2 <= '0;
         v2 <= 1'b0;
      end else begin
         v1 <= rd;
         if (rd) d1 <= rword;
         v2 <= v1;
         if (v1) d2 <= d1;
      end
   end
   assign Do    = OUT_REG != 0 ? d2 : d1;
   assign VALID = OUT_REG != 0 ? v2 : v1;
endmodule

// File: tb/tb_ram_banked_init.sv
// tb_ram_banked_init: directed checks of fill, byte writes, read latency and reset behaviour.
module tb_ram_banked_init;
   logic clk, rst, en;
   logic [7:0] we;
   logic [8:0] a;
   logic [63:0] di, dout0, dout1;
   logic valid0, valid1, busy0, busy1;
   int n_chk, n_fail;

   typedef struct {
      logic        en;
      logic [7:0]  we;
      logic [8:0]  a;
      logic [63:0] di;
      logic        ev;
      logic [63:0] edo;
   } vec_t;
   vec_t vt [20];

   ram_banked_init dut0 (.CLK(clk), .RST(rst), .EN(en), .WE(we), .A(a), .Di(di),
                         .Do(dout0), .VALID(valid0), .BUSY(busy0));
   ram_banked_init #(.OUT_REG(1)) dut1 (.CLK(clk), .RST(rst), .EN(en), .WE(we), .A(a), .Di(di),
                                        .Do(dout1), .VALID(valid1), .BUSY(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_fill(input string nm);
      int n, bad;
      n = 0;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (!busy0) break;
         if (valid0 || valid1 || dout0 != 0 || dout1 != 0) bad++;
      end
      check({nm, "_busy_cycles"}, 64'(n), 64'd512);
      check({nm, "_quiet_outputs"}, 64'(bad), 64'd0);
      check({nm, "_busy_r"}, 64'(busy1), 64'd0);
   endtask

   task automatic drive(input logic e, input logic [7:0] w, input logic [8:0] ad, input logic [63:0] d);
      en = e;
      we = w;
      a  = ad;
      di = d;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      vt[0]  = '{1, 8'h00, 9'h000, 64'h0, 1, 64'h0};
      vt[1]  = '{1, 8'h00, 9'h1FF, 64'h0, 1, 64'h0};
      vt[2]  = '{1, 8'h00, 9'h0AA, 64'h0, 1, 64'h0};
      vt[3]  = '{1, 8'h00, 9'h010, 64'h0, 1, 64'h0};
      vt[4]  = '{1, 8'hFF, 9'h005, 64'h1122334455667788, 0, 64'h0};
      vt[5]  = '{1, 8'h0F, 9'h005, 64'hAAAAAAAAAAAAAAAA, 0, 64'h0};
      vt[6]  = '{1, 8'h00, 9'h005, 64'h0, 1, 64'h11223344AAAAAAAA};
      vt[7]  = '{0, 8'hFF, 9'h005, 64'h0, 0, 64'h11223344AAAAAAAA};
      vt[8]  = '{1, 8'h00, 9'h005, 64'h0, 1, 64'h11223344AAAAAAAA};
      vt[9]  = '{1, 8'hF0, 9'h100, 64'hDEADBEEF00000000, 0, 64'h11223344AAAAAAAA};
      vt[10] = '{1, 8'h00, 9'h100, 64'h0, 1, 64'hDEADBEEF00000000};
      vt[11] = '{0, 8'h00, 9'h100, 64'h0, 0, 64'hDEADBEEF00000000};
      vt[12] = '{0, 8'h00, 9'h000, 64'h0, 0, 64'hDEADBEEF00000000};
      vt[13] = '{0, 8'h00, 9'h1FF, 64'h0, 0, 64'hDEADBEEF00000000};
      vt[14] = '{1, 8'hFF, 9'h001, 64'h1, 0, 64'hDEADBEEF00000000};
      vt[15] = '{1, 8'hFF, 9'h002, 64'h2, 0, 64'hDEADBEEF00000000};
      vt[16] = '{1, 8'hFF, 9'h003, 64'h3, 0, 64'hDEADBEEF00000000};
      vt[17] = '{1, 8'hFF, 9'h004, 64'h4, 0, 64'hDEADBEEF00000000};
      vt[18] = '{1, 8'h00, 9'h004, 64'h0, 1, 64'h4};
      vt[19] = '{0, 8'h00, 9'h000, 64'h0, 0, 64'h4};

      rst = 1'b1;
      drive(1, 8'hFF, 9'h010, '1);
      repeat (2) @(posedge clk);
      #1;
      check("reset_do", dout0, 64'h0);
      check("reset_valid", 64'(valid0), 64'd0);
      check("reset_busy", 64'(busy0), 64'd1);
      check("reset_valid_r", 64'(valid1), 64'd0);
      rst = 1'b0;
      wait_fill("fill");
      drive(0, 8'h00, 9'h000, 64'h0);

      for (int i = 0; i < 20; i++) begin
         drive(vt[i].en, vt[i].we, vt[i].a, vt[i].di);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), 64'(valid0), 64'(vt[i].ev));
         check($sformatf("vec%0d_do", i), dout0, vt[i].edo);
      end

      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive(1, 8'h00, 9'(i + 1), 64'h0);
         else drive(0, 8'h00, 9'h000, 64'h0);
         @(posedge clk);
         #1;
         check($sformatf("pipe%0d_valid", i), 64'(valid1), 64'(i >= 1 && i <= 4));
         if (i >= 1 && i <= 4) check($sformatf("pipe%0d_do", i), dout1, 64'(i));
      end

      drive(1, 8'h00, 9'h100, 64'h0);
      @(posedge clk);
      #1;
      check("midread_valid", 64'(valid0), 64'd1);
      check("midread_do", dout0, 64'hDEADBEEF00000000);
      check("midread_inflight", 64'(valid1), 64'd0);
      rst = 1'b1;
      drive(0, 8'h00, 9'h000, 64'h0);
      @(posedge clk);
      #1;
      check("rstread_valid_r", 64'(valid1), 64'd0);
      check("rstread_do_r", dout1, 64'h0);
      check("rstread_do", dout0, 64'h0);
      check("rstread_busy", 64'(busy0), 64'd1);
      rst = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midfill_busy", 64'(busy0), 64'd1);
      wait_fill("refill");

      drive(1, 8'h00, 9'h100, 64'h0);
      @(posedge clk);
      #1;
      drive(0, 8'h00, 9'h000, 64'h0);
      check("refill_valid", 64'(valid0), 64'd1);
      check("refill_do", dout0, 64'h0);
      @(posedge clk);
      #1;
      check("refill_valid_r", 64'(valid1), 64'd1);
      check("refill_do_r", dout1, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
